// File: rtl/fetch_pkg.sv
// Shared fetch-path types and default sizes for the fetch queue.
// FETCH_WIDTH / INST_ADDR_WIDTH may be overridden by macros of the same name.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

package fetch_pkg;

  localparam int FQ_FETCH_WIDTH_DEFAULT     = `FETCH_WIDTH;
  localparam int FQ_INST_ADDR_WIDTH_DEFAULT = `INST_ADDR_WIDTH;
  localparam int FQ_DEPTH_DEFAULT           = 4;

  typedef struct packed {
    logic [FQ_FETCH_WIDTH_DEFAULT-1:0][31:0] inst;
    logic [FQ_INST_ADDR_WIDTH_DEFAULT-1:0]   pc;
    logic [FQ_INST_ADDR_WIDTH_DEFAULT-1:0]   pc_plus_4;
    logic                                    last;
  } fetch_bundle_t;

  // Occupancy counter width able to represent 0..depth inclusive.
  function automatic int fq_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// IFU -> fetch queue -> decode handshake bundle.
// master = IFU/decode side driving the queue, slave = the queue itself.
interface fetch_queue_if
  import fetch_pkg::*;
#(
  parameter int FETCH_WIDTH     = FQ_FETCH_WIDTH_DEFAULT,
  parameter int INST_ADDR_WIDTH = FQ_INST_ADDR_WIDTH_DEFAULT,
  parameter int DEPTH           = FQ_DEPTH_DEFAULT
);
  localparam int CNT_W = fq_cnt_w(DEPTH);

  logic                            flush;
  logic                            in_valid;
  logic                            in_ready;
  logic [FETCH_WIDTH-1:0][31:0]    in_inst;
  logic [INST_ADDR_WIDTH-1:0]      in_pc;
  logic [INST_ADDR_WIDTH-1:0]      in_pc_plus_4;
  logic                            in_last;
  logic                            out_valid;
  logic                            out_ready;
  logic [FETCH_WIDTH-1:0][31:0]    out_inst;
  logic [INST_ADDR_WIDTH-1:0]      out_pc;
  logic [INST_ADDR_WIDTH-1:0]      out_pc_plus_4;
  logic                            out_drained;
  logic [CNT_W-1:0]                occupancy;

  modport master (
    output flush, in_valid, in_inst, in_pc, in_pc_plus_4, in_last, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_pc_plus_4, out_drained, occupancy
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, in_pc_plus_4, in_last, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_pc_plus_4, out_drained, occupancy
  );

endinterface

// File: rtl/fq_ptr.sv
// Wrap-around index counter 0..DEPTH-1 with synchronous clear and increment.
module fq_ptr #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  // Clear wins over increment so a redirect always restarts at entry 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Multi-entry fetch bundle queue between IFU and decode with redirect flush.
// Optional zero-latency empty-queue bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int FETCH_WIDTH     = FQ_FETCH_WIDTH_DEFAULT,
  parameter int INST_ADDR_WIDTH = FQ_INST_ADDR_WIDTH_DEFAULT,
  parameter int DEPTH           = FQ_DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  bus
);

  localparam int CNT_W = fq_cnt_w(DEPTH);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [FETCH_WIDTH-1:0][31:0] inst_mem [DEPTH];
  logic [INST_ADDR_WIDTH-1:0]   pc_mem   [DEPTH];
  logic [INST_ADDR_WIDTH-1:0]   pc4_mem  [DEPTH];

  logic [CNT_W-1:0] count;
  logic             last_seen;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic in_ready;
  logic q_valid;
  logic push;
  logic pop;
  logic wr_en;

  assign in_ready = (count != FULL);
  assign q_valid  = (count != '0);
  assign push     = bus.in_valid & in_ready & ~bus.flush;
  assign pop      = q_valid & bus.out_ready & ~bus.flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  logic bypass_take;

  // An empty queue forwards the incoming bundle straight to decode; if decode
  // takes it this cycle it never occupies an entry.
  assign bypass      = ~q_valid & bus.in_valid & ~bus.flush;
  assign bypass_take = bypass & bus.out_ready;
  assign wr_en       = push & ~bypass_take;

  assign bus.out_valid     = q_valid | bypass;
  assign bus.out_inst      = bypass ? bus.in_inst      : inst_mem[rd_ptr];
  assign bus.out_pc        = bypass ? bus.in_pc        : pc_mem[rd_ptr];
  assign bus.out_pc_plus_4 = bypass ? bus.in_pc_plus_4 : pc4_mem[rd_ptr];
`else
  assign wr_en = push;

  assign bus.out_valid     = q_valid;
  assign bus.out_inst      = inst_mem[rd_ptr];
  assign bus.out_pc        = pc_mem[rd_ptr];
  assign bus.out_pc_plus_4 = pc4_mem[rd_ptr];
`endif

  assign bus.in_ready    = in_ready;
  assign bus.out_drained = last_seen & ~q_valid;
  assign bus.occupancy   = count;

  fq_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_en),
    .clear (bus.flush),
    .ptr   (wr_ptr)
  );

  fq_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop),
    .clear (bus.flush),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (bus.flush) begin
      count <= '0;
    end else begin
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_seen <= 1'b0;
    end else if (bus.flush) begin
      last_seen <= 1'b0;
    end else if (push && bus.in_last) begin
      last_seen <= 1'b1;
    end
  end

  // Storage is left untouched by flush; only the pointers and count restart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
        pc4_mem[i]  <= '0;
      end
    end else if (wr_en) begin
      inst_mem[wr_ptr] <= bus.in_inst;
      pc_mem[wr_ptr]   <= bus.in_pc;
      pc4_mem[wr_ptr]  <= bus.in_pc_plus_4;
    end
  end

  a_in_stable: assert property (@(posedge clk) disable iff (!reset)
    (bus.in_valid && !in_ready && !bus.flush) |=>
      (bus.in_valid && $stable(bus.in_inst) && $stable(bus.in_pc) &&
       $stable(bus.in_pc_plus_4) && $stable(bus.in_last)));

  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
    count <= FULL);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table, hand sequences and a random run
// against a queue-based reference model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int FW    = FQ_FETCH_WIDTH_DEFAULT;
  localparam int AW    = FQ_INST_ADDR_WIDTH_DEFAULT;
  localparam int DEPTH = FQ_DEPTH_DEFAULT;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  fetch_queue_if #(.FETCH_WIDTH(FW), .INST_ADDR_WIDTH(AW), .DEPTH(DEPTH)) bif ();

  fetch_queue #(.FETCH_WIDTH(FW), .INST_ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    logic        last;
    int          occ;
    logic        ov;
    logic [31:0] opc;
    logic        pc_chk;
    logic        ir;
    logic        drn;
  } vec_t;

  vec_t tbl [26];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc, input logic ordy,
                       input logic fl, input logic last);
    bif.in_valid     = iv;
    bif.in_pc        = AW'(pc);
    bif.in_pc_plus_4 = AW'(pc + 32'd4);
    bif.in_last      = last;
    bif.out_ready    = ordy;
    bif.flush        = fl;
    for (int k = 0; k < FW; k++) bif.in_inst[k] = 32'h1300_0013 + pc + 32'(k);
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Cycle helper: inputs held over one rising edge, then released.
  task automatic cycle_then_idle();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  function automatic fetch_bundle_t rand_bundle();
    fetch_bundle_t b;
    for (int k = 0; k < FW; k++) b.inst[k] = $urandom;
    b.pc        = AW'({$urandom, 2'b00});
    b.pc_plus_4 = b.pc + AW'(4);
    b.last      = ($urandom_range(0, 15) == 0);
    return b;
  endfunction

  initial begin
    logic [31:0]   pcq [$];
    fetch_bundle_t mq  [$];
    fetch_bundle_t cur;
    logic          cur_iv, cur_or, cur_fl, hold, ls;
    logic          e_ir, e_ov, push_m, pop_m;
    fetch_bundle_t head;

    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    idle();

    // ---- reset state
    #12;
    chk("rst_in_ready",  64'(bif.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bif.out_valid), 64'd0);
    chk("rst_out_pc",    64'(bif.out_pc), 64'd0);
    chk("rst_out_pc4",   64'(bif.out_pc_plus_4), 64'd0);
    chk("rst_out_inst",  64'(bif.out_inst[0]), 64'd0);
    chk("rst_drained",   64'(bif.out_drained), 64'd0);
    chk("rst_occ",       64'(bif.occupancy), 64'd0);
    #6 reset = 1'b1;
    @(posedge clk);
    #1;

    // ---- vector table: {iv, pc, ordy, fl, last, occ, ov, opc, pc_chk, ir, drn}
    tbl[0]  = '{1'b1, 32'h00, 1'b0, 1'b0, 1'b0, 1, 1'b1, 32'h00, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 32'h04, 1'b0, 1'b0, 1'b0, 2, 1'b1, 32'h00, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 32'h08, 1'b0, 1'b0, 1'b0, 3, 1'b1, 32'h00, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 2, 1'b1, 32'h04, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1, 1'b1, 32'h08, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 2, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 32'h18, 1'b0, 1'b0, 1'b0, 3, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 32'h1C, 1'b0, 1'b0, 1'b0, 4, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 4, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 3, 1'b1, 32'h14, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 4, 1'b1, 32'h14, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 3, 1'b1, 32'h18, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 2, 1'b1, 32'h1C, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1, 1'b1, 32'h20, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 32'h30, 1'b0, 1'b0, 1'b1, 1, 1'b1, 32'h30, 1'b1, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1};
    tbl[19] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0};
    tbl[20] = '{1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0};
    tbl[21] = '{1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 2, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0};
    tbl[22] = '{1'b1, 32'h48, 1'b0, 1'b0, 1'b0, 3, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0};
    tbl[23] = '{1'b1, 32'h4C, 1'b1, 1'b1, 1'b0, 0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0};
    tbl[24] = '{1'b1, 32'h50, 1'b0, 1'b0, 1'b0, 1, 1'b1, 32'h50, 1'b1, 1'b1, 1'b0};
    tbl[25] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].iv, tbl[i].pc, tbl[i].ordy, tbl[i].fl, tbl[i].last);
      cycle_then_idle();
      chk($sformatf("vec%0d_occ", i), 64'(bif.occupancy), 64'(tbl[i].occ));
      chk($sformatf("vec%0d_out_valid", i), 64'(bif.out_valid), 64'(tbl[i].ov));
      chk($sformatf("vec%0d_in_ready", i), 64'(bif.in_ready), 64'(tbl[i].ir));
      chk($sformatf("vec%0d_drained", i), 64'(bif.out_drained), 64'(tbl[i].drn));
      if (tbl[i].pc_chk)
        chk($sformatf("vec%0d_out_pc", i), 64'(bif.out_pc), 64'(tbl[i].opc));
    end

    // ---- simultaneous push/pop at count=2 across pointer wrap
    pcq.delete();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      pcq.push_back(32'h100 + 32'(4 * i));
      cycle_then_idle();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h108 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
      pcq.push_back(32'h108 + 32'(4 * i));
      void'(pcq.pop_front());
      cycle_then_idle();
      chk($sformatf("pp%0d_occ", i), 64'(bif.occupancy), 64'd2);
      chk($sformatf("pp%0d_out_pc", i), 64'(bif.out_pc), 64'(pcq[0]));
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle_then_idle();
    chk("pp_tail_pc", 64'(bif.out_pc), 64'(pcq[1]));
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle_then_idle();
    chk("pp_drain_occ", 64'(bif.occupancy), 64'd0);

    // ---- empty-queue latency (bypass vs registered)
    drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_same_valid", 64'(bif.out_valid), 64'd1);
    chk("byp_same_pc", 64'(bif.out_pc), 64'h40);
    cycle_then_idle();
    chk("byp_occ", 64'(bif.occupancy), 64'd0);
    chk("byp_after_valid", 64'(bif.out_valid), 64'd0);
`else
    chk("lat_same_valid", 64'(bif.out_valid), 64'd0);
    cycle_then_idle();
    chk("lat_next_valid", 64'(bif.out_valid), 64'd1);
    chk("lat_next_pc", 64'(bif.out_pc), 64'h40);
    chk("lat_next_occ", 64'(bif.occupancy), 64'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle_then_idle();
    chk("lat_pop_occ", 64'(bif.occupancy), 64'd0);
`endif

    // ---- asynchronous reset mid-stream
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      cycle_then_idle();
    end
    chk("ar_pre_occ", 64'(bif.occupancy), 64'd2);
    #1 reset = 1'b0;
    #1;
    chk("ar_out_valid", 64'(bif.out_valid), 64'd0);
    chk("ar_occ", 64'(bif.occupancy), 64'd0);
    chk("ar_in_ready", 64'(bif.in_ready), 64'd1);
    chk("ar_out_pc", 64'(bif.out_pc), 64'd0);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    // ---- randomized run against the reference model
    mq.delete();
    ls   = 1'b0;
    hold = 1'b0;
    cur  = rand_bundle();
    cur_iv = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!hold) begin
        cur    = rand_bundle();
        cur_iv = ($urandom_range(0, 3) != 0);
      end
      cur_or = ((c / 100) % 2 == 1) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      cur_fl = ($urandom_range(0, 29) == 0);
      bif.in_valid     = cur_iv;
      bif.in_inst      = cur.inst;
      bif.in_pc        = cur.pc;
      bif.in_pc_plus_4 = cur.pc_plus_4;
      bif.in_last      = cur.last;
      bif.out_ready    = cur_or;
      bif.flush        = cur_fl;
      #1;

      e_ir = (mq.size() < DEPTH);
      e_ov = (mq.size() != 0) || (BYP && cur_iv && !cur_fl);
      head = (mq.size() != 0) ? mq[0] : cur;
      chk("rnd_in_ready", 64'(bif.in_ready), 64'(e_ir));
      chk("rnd_out_valid", 64'(bif.out_valid), 64'(e_ov));
      chk("rnd_occ", 64'(bif.occupancy), 64'(mq.size()));
      chk("rnd_drained", 64'(bif.out_drained), 64'(ls && mq.size() == 0));
      if (e_ov) begin
        chk("rnd_out_pc", 64'(bif.out_pc), 64'(head.pc));
        chk("rnd_out_pc4", 64'(bif.out_pc_plus_4), 64'(head.pc_plus_4));
        for (int k = 0; k < FW; k++)
          chk("rnd_out_inst", 64'(bif.out_inst[k]), 64'(head.inst[k]));
      end

      if (cur_fl) begin
        mq.delete();
        ls = 1'b0;
      end else begin
        push_m = cur_iv && e_ir;
        pop_m  = e_ov && cur_or;
        if (push_m && cur.last) ls = 1'b1;
        if (mq.size() == 0 && push_m && pop_m) begin
          // bundle handed straight to decode, nothing retained
        end else begin
          if (pop_m) void'(mq.pop_front());
          if (push_m) mq.push_back(cur);
        end
      end
      hold = cur_iv && !e_ir && !cur_fl;

      @(posedge clk);
      #1;
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised, multi-entry fetch buffer between the IFU and decode/rename.
- Replaces the single-stage, stall-enabled output register on the fetch path.
- Holds up to DEPTH fetch bundles of FETCH_WIDTH instructions each, with their PC and PC+4.
- Upstream and downstream use independent valid/ready handshakes; a branch-redirect flush discards all queued bundles in one cycle.

Parameters:
- FETCH_WIDTH, default `FETCH_WIDTH: instructions per bundle (>=1).
- INST_ADDR_WIDTH, default `INST_ADDR_WIDTH: PC width.
- DEPTH, default 4: bundle entries (>=2; need not be a power of 2).
- CNT_W, default $clog2(DEPTH+1): occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  redirect: discard all entries.
- in_valid  in  1  IFU presents a bundle.
- in_ready  out  1  queue accepts a bundle; IFU stall = ~in_ready.
- in_inst  in  [FETCH_WIDTH-1:0][31:0]  instruction codes.
- in_pc  in  INST_ADDR_WIDTH  bundle PC.
- in_pc_plus_4  in  INST_ADDR_WIDTH  bundle PC+4.
- in_last  in  1  bundle carries the last program instruction.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode consumes head.
- out_inst  out  [FETCH_WIDTH-1:0][31:0]  head instructions.
- out_pc  out  INST_ADDR_WIDTH  head PC.
- out_pc_plus_4  out  INST_ADDR_WIDTH  head PC+4.
- out_drained  out  1  last instruction seen and queue empty.
- occupancy  out  CNT_W  entries held.

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr, rd_ptr, count, last_seen and all storage go to 0.
  - Outputs then read: in_ready=1, out_valid=0, out_inst/out_pc/out_pc_plus_4=0, out_drained=0, occupancy=0.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Handshake signals:
  - in_ready = (count != DEPTH). It does not depend on out_ready, so there is no combinational ready path.
  - out_valid = (count != 0).
- Push = in_valid & in_ready & ~flush. On push, the entry at wr_ptr is written and wr_ptr increments, wrapping DEPTH-1 -> 0.
- Pop = out_valid & out_ready & ~flush. On pop, rd_ptr increments with the same wrap.
- count update: count+1 on push only; count-1 on pop only; unchanged on push and pop together.
  - Simultaneous push and pop is legal whenever count is between 1 and DEPTH-1.
  - When full, push is blocked even if out_ready=1. A pop from full makes in_ready=1 on the next cycle.
- Head data: out_* are driven combinationally from storage[rd_ptr] (registered storage, no extra latency).
  - Values are don't-care when out_valid=0, except immediately after reset, when they are 0.
- Latency: a bundle pushed at edge N is visible on out_* with out_valid=1 after edge N (one cycle).
- Flush:
  - At the next edge, wr_ptr=rd_ptr=0, count=0 and last_seen=0.
  - Flush overrides a push or pop in the same cycle; that input bundle is dropped.
  - Storage contents are not cleared.
- last_seen: set on a push with in_last=1; cleared only by flush or reset.
- out_drained = last_seen & (count==0).
- occupancy = count.
- Assertions:
  - in_* must be held stable while in_valid=1 and in_ready=0.
  - count never exceeds DEPTH.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count==0 and in_valid=1 and flush=0, out_valid=1 and out_* are driven combinationally from in_*.
  - If out_ready=1 in that cycle, the bundle is consumed and not written: no pointer move, count stays 0.
  - If out_ready=0, the bundle is written normally.
  - Zero-cycle latency when empty.
- Undefined: no bypass; fixed one-cycle latency as specified above.

Decomposition:
- Shared package (fetch_pkg), holding:
  - fetch_bundle_t struct (inst array, pc, pc_plus_4, last);
  - the FETCH_WIDTH and INST_ADDR_WIDTH defaults;
  - the FQ_DEPTH_DEFAULT constant.
- One natural sub-module: fq_ptr, a wrap-around pointer counter parametrised by DEPTH with inc/clear inputs, instantiated as wr_ptr and rd_ptr.

Test Plan:
- Reset, then push 3 bundles with pc=0x00, 0x04, 0x08 and out_ready=0 -> occupancy=3, out_pc=0x00. Set out_ready=1 -> pops in order 0x00, 0x04, 0x08, then out_valid=0.
- Fill DEPTH=4 with out_ready=0 -> in_ready=0 on the cycle after the 4th push. A 5th in_valid is held off. One pop -> in_ready=1 next cycle; the 5th bundle is accepted with wr_ptr wrapped to 0.
- count=2, push and pop in the same cycle -> count stays 2 and order is preserved across wrap, over 10 consecutive cycles.
- count=3, flush=1 together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1; the concurrent bundle is absent.
- Push a bundle with in_last=1, then drain -> out_drained=1 only once count=0. A following flush -> out_drained=0.
- With FETCH_QUEUE_BYPASS_EN, empty queue, in_valid=1 with in_pc=0x40, out_ready=1 -> out_valid=1 and out_pc=0x40 in the same cycle, occupancy stays 0. Without the macro, the same stimulus gives out_valid=1 one cycle later.
- Assert reset low mid-stream with count=2 -> out_valid=0 and occupancy=0 immediately, without waiting for a clock edge.
